// File: rtl/lp_arith_sequencer.sv
// Issue/capture sequencer around a combinational add/sub/mul unit.
// Keeps the unit parked at op=11 with zero operands unless an op is executing.
module lp_arith_sequencer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic [1:0]         in_op,
    output logic [WIDTH-1:0]   alu_a,
    output logic [WIDTH-1:0]   alu_b,
    output logic [1:0]         alu_op,
    input  logic [2*WIDTH-1:0] alu_result,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_data,
    output logic [1:0]         out_op,
    output logic               busy,
    output logic [CNT_W-1:0]   op_count
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE
    } state_t;

    localparam logic [1:0] OP_NOP = 2'b11;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic [1:0]       req_op;
    logic             accept;
    logic             issue;
    logic             exec;
    logic             handoff;

    assign in_ready = (state == IDLE) || (state == DONE && out_ready);
    assign accept   = in_valid && in_ready;
    assign issue    = accept && (in_op != OP_NOP);
    assign exec     = (state == EXEC);
    assign handoff  = out_valid && out_ready;
    assign busy     = (state != IDLE);

    // Operands only reach the unit during EXEC so it never toggles otherwise.
    assign alu_a  = exec ? req_a : '0;
    assign alu_b  = exec ? req_b : '0;
    assign alu_op = exec ? req_op : OP_NOP;

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (issue) state_nx = EXEC;
            EXEC: state_nx = DONE;
            DONE: begin
                if (out_ready) state_nx = issue ? EXEC : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            req_a     <= '0;
            req_b     <= '0;
            req_op    <= '0;
            out_data  <= '0;
            out_op    <= '0;
            out_valid <= 1'b0;
            op_count  <= '0;
        end else begin
            state <= state_nx;
            if (issue) begin
                req_a  <= in_a;
                req_b  <= in_b;
                req_op <= in_op;
            end
            if (exec) begin
                out_data  <= alu_result;
                out_op    <= req_op;
                out_valid <= 1'b1;
            end else if (handoff) begin
                out_valid <= 1'b0;
            end
            if (handoff) op_count <= op_count + 1'b1;
        end
    end

endmodule
